bitonic_sort_ctrl: RTL and testbench

Bus-attached sequencer for the 8 × 32-bit combinational bitonic sorting network on the NEXYS4_DDR UDM debug bus. It holds the unsorted operand registers that drive the network and accepts a start command. It waits a programmable settle time, since the network is a multicycle combinational path, then captures the sorted result into read-back registers and reports busy/done status. It replaces ad-hoc CSR decoding in the top level with a single slave on the MemSplit32-style bus.

---
 rtl/bitonic_sort_ctrl.sv | 152 +++++++++++++++
 tb/tb_bitonic_sort_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/bitonic_sort_ctrl.sv
// Bus-attached sequencer for the 8 x 32-bit combinational bitonic sorting network.
// Optional feature: define BITONIC_CTRL_AUTOSTART_EN so that an idle write to IN[7] also starts a sort.
module bitonic_sort_ctrl #(
  parameter logic [31:0] BASE_ADDR     = 32'h00000010,
  parameter int          SETTLE_CYCLES = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         bus_req_i,
  input  logic         bus_we_i,
  input  logic [31:0]  bus_addr_bi,
  input  logic [3:0]   bus_be_bi,
  input  logic [31:0]  bus_wdata_bi,
  output logic         bus_ack_o,
  output logic         bus_resp_o,
  output logic [31:0]  bus_rdata_bo,
  output logic [255:0] sort_list_bo,
  input  logic [255:0] sort_list_bi,
  output logic         busy_o,
  output logic         done_o
);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE} state_t;

  state_t      state, state_next;
  logic [7:0]  cnt;
  logic [31:0] in_reg  [8];
  logic [31:0] out_reg [8];
  logic [31:0] sort_cnt;
  logic        done, err;

  logic [31:0] off;
  logic [4:0]  widx, in_sel, out_sel;
  logic [2:0]  in_idx, out_idx;
  logic        in_win, wr_acc, rd_acc, is_ctrl, is_in;
  logic        busy, ctrl_wr, start_req, start, err_set, in_wr, capture;
  logic [31:0] rd_val;

  function automatic logic [31:0] merge_be(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++)
      res[8*b +: 8] = be[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    return res;
  endfunction

  // Decode: the unsigned offset wraps for addresses below the base, so one compare bounds the window.
  assign off     = bus_addr_bi - BASE_ADDR;
  assign in_win  = (off < 32'h50);
  assign widx    = off[6:2];
  assign in_sel  = widx - 5'd4;
  assign out_sel = widx - 5'd12;
  assign in_idx  = in_sel[2:0];
  assign out_idx = out_sel[2:0];
  assign wr_acc  = bus_req_i & bus_we_i & in_win;
  assign rd_acc  = bus_req_i & ~bus_we_i & in_win;
  assign is_ctrl = (widx == 5'd0);
  assign is_in   = (widx >= 5'd4) && (widx <= 5'd11);

  assign busy    = (state != IDLE);
  assign capture = (state == CAPTURE);
  assign ctrl_wr = wr_acc & is_ctrl;
`ifdef BITONIC_CTRL_AUTOSTART_EN
  assign start_req = (ctrl_wr & bus_wdata_bi[0]) | (wr_acc & is_in & (in_idx == 3'd7));
`else
  assign start_req = ctrl_wr & bus_wdata_bi[0];
`endif
  assign start   = start_req & ~busy;
  assign in_wr   = wr_acc & is_in & ~busy;
  assign err_set = busy & wr_acc & (is_in | (is_ctrl & bus_wdata_bi[0]));

  assign bus_ack_o = bus_req_i;
  assign busy_o    = busy;
  assign done_o    = done;

  always_comb begin
    sort_list_bo = '0;
    for (int i = 0; i < 8; i++)
      sort_list_bo[32*i +: 32] = in_reg[i];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SETTLE;
      SETTLE:  if (cnt == 8'd0) state_next = CAPTURE;
      CAPTURE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rd_val = '0;
    if (widx == 5'd1)
      rd_val = {29'd0, err, done, busy};
    else if (widx == 5'd2)
      rd_val = sort_cnt;
    else if (is_in)
      rd_val = in_reg[in_idx];
    else if ((widx >= 5'd12) && (widx <= 5'd19))
      rd_val = out_reg[out_idx];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (start)
        cnt <= 8'(SETTLE_CYCLES - 1);
      else if ((state == SETTLE) && (cnt != 8'd0))
        cnt <= cnt - 8'd1;
    end
  end

  // Register file, status flags and the registered read port.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 8; i++) begin
        in_reg[i]  <= '0;
        out_reg[i] <= '0;
      end
      sort_cnt     <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
      bus_resp_o   <= 1'b0;
      bus_rdata_bo <= '0;
    end else begin
      if (in_wr)
        in_reg[in_idx] <= merge_be(in_reg[in_idx], bus_wdata_bi, bus_be_bi);
      if (capture) begin
        for (int i = 0; i < 8; i++)
          out_reg[i] <= sort_list_bi[32*i +: 32];
        sort_cnt <= sort_cnt + 32'd1;
      end
      // A capture in the same cycle as CLR_DONE leaves the fresh result flagged.
      if (capture)
        done <= 1'b1;
      else if (ctrl_wr && bus_wdata_bi[1])
        done <= 1'b0;
      if (err_set)
        err <= 1'b1;
      else if (ctrl_wr && bus_wdata_bi[2])
        err <= 1'b0;
      bus_resp_o   <= rd_acc;
      bus_rdata_bo <= rd_acc ? rd_val : 32'd0;
    end
  end

endmodule

// File: tb/tb_bitonic_sort_ctrl.sv
// Scoreboard bench for bitonic_sort_ctrl with a behavioural sorting network on the result inputs.
module tb_bitonic_sort_ctrl;

  localparam logic [31:0] BASE = 32'h00000010;
  localparam int          SC   = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         bus_req = 1'b0, bus_we = 1'b0;
  logic [31:0]  bus_addr = '0, bus_wdata = '0;
  logic [3:0]   bus_be = '0;
  logic         bus_ack, bus_resp, busy, done;
  logic [31:0]  bus_rdata;
  logic [255:0] list_out, list_in;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] data;
    int          cyc;
    logic [31:0] off;
  } exp_t;
  exp_t sb[$];

  bitonic_sort_ctrl #(.BASE_ADDR(BASE), .SETTLE_CYCLES(SC)) dut (
    .clk_i(clk), .rst_i(rst), .bus_req_i(bus_req), .bus_we_i(bus_we),
    .bus_addr_bi(bus_addr), .bus_be_bi(bus_be), .bus_wdata_bi(bus_wdata),
    .bus_ack_o(bus_ack), .bus_resp_o(bus_resp), .bus_rdata_bo(bus_rdata),
    .sort_list_bo(list_out), .sort_list_bi(list_in),
    .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [255:0] net_sort(input logic [255:0] v);
    logic [31:0] a [8];
    logic [31:0] t;
    logic [255:0] r;
    for (int i = 0; i < 8; i++) a[i] = v[32*i +: 32];
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 7 - i; j++)
        if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
    for (int i = 0; i < 8; i++) r[32*i +: 32] = a[i];
    return r;
  endfunction

  assign list_in = net_sort(list_out);

  // Monitor: every read response must match the oldest queued expectation, one cycle after issue.
  always @(negedge clk) begin
    if (bus_req) begin
      total++;
      if (bus_ack !== bus_req) begin
        bad++;
        $display("FAIL ack got=%b want=%b", bus_ack, bus_req);
      end
    end
    if (bus_resp) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_resp got data=%h want no response", bus_rdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus_rdata !== e.data || cyc != e.cyc) begin
          bad++;
          $display("FAIL rd off=%h got=%h@%0d want=%h@%0d", e.off, bus_rdata, cyc, e.data, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic wr(input logic [31:0] offs, input logic [31:0] d, input logic [3:0] be);
    bus_req = 1'b1; bus_we = 1'b1; bus_addr = BASE + offs; bus_wdata = d; bus_be = be;
    @(posedge clk); #1;
    bus_req = 1'b0; bus_we = 1'b0;
  endtask

  task automatic rd_raw(input logic [31:0] addr);
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = addr;
    @(posedge clk); #1;
    bus_req = 1'b0;
  endtask

  task automatic rd(input logic [31:0] offs, input logic [31:0] want);
    exp_t e;
    e.data = want; e.cyc = cyc + 1; e.off = offs;
    sb.push_back(e);
    rd_raw(BASE + offs);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 50) begin
      n++;
      @(posedge clk); #1;
    end
    if (n >= 50) begin
      total++; bad++;
      $display("FAIL wait_idle got=busy want=idle within 50 cycles");
    end
  endtask

  initial begin
    int n;
    logic [31:0] vals [8];
    logic [31:0] sorted [8];
    vals   = '{32'd7, 32'd3, 32'd9, 32'd1, 32'd8, 32'd2, 32'd6, 32'd5};
    sorted = '{32'd1, 32'd2, 32'd3, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("busy_rst", {31'd0, busy}, 32'd0);
    chk("done_rst", {31'd0, done}, 32'd0);
    rd(32'h04, 32'd0);
    rd(32'h08, 32'd0);
    rd(32'h30, 32'd0);
    rd(32'h00, 32'd0);

    // Byte-enable merge on IN[0]
    wr(32'h10, 32'h12345678, 4'hF);
    wr(32'h10, 32'hAABBCCDD, 4'b0101);
    rd(32'h10, 32'h12BB56DD);

    // First sort
    for (int i = 0; i < 8; i++) wr(32'h10 + 4*i, vals[i], 4'hF);
    rd(32'h18, 32'd9);
    wr(32'h00, 32'h1, 4'hF);
    wait_idle(n);
    chk("busy_cycles", n, SC + 1);
    chk("done_after", {31'd0, done}, 32'd1);
    for (int i = 0; i < 8; i++) rd(32'h30 + 4*i, sorted[i]);
    rd(32'h08, 32'd1);
    rd(32'h04, 32'd2);
    wr(32'h30, 32'hDEAD, 4'hF);
    wr(32'h08, 32'h55, 4'hF);
    rd(32'h30, 32'd1);
    rd(32'h08, 32'd1);
    rd(32'h04, 32'd2);

    // Writes while busy are dropped and raise err
    wr(32'h00, 32'h1, 4'hF);
    wr(32'h10, 32'd100, 4'hF);
    wr(32'h00, 32'h1, 4'hF);
    rd(32'h4C, 32'd9);
    wait_idle(n);
    rd(32'h10, 32'd7);
    rd(32'h30, 32'd1);
    rd(32'h4C, 32'd9);
    rd(32'h08, 32'd2);
    rd(32'h04, 32'd6);
    wr(32'h00, 32'h4, 4'hF);
    rd(32'h04, 32'd2);

    // CLR_DONE + START together, new operand set
    wr(32'h1C, 32'd256, 4'hF);
    wr(32'h00, 32'h3, 4'hF);
    chk("done_cleared", {31'd0, done}, 32'd0);
    chk("busy_started", {31'd0, busy}, 32'd1);
    rd(32'h04, 32'd1);
    rd(32'h30, 32'd1);
    wait_idle(n);
    chk("done_reset", {31'd0, done}, 32'd1);
    rd(32'h30, 32'd2);
    rd(32'h4C, 32'd256);
    rd(32'h08, 32'd3);
    rd(32'h04, 32'd2);

    // Reset two cycles into SETTLE
    wr(32'h00, 32'h1, 4'hF);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("busy_abort", {31'd0, busy}, 32'd0);
    chk("done_abort", {31'd0, done}, 32'd0);
    repeat (6) @(posedge clk);
    #1;
    chk("busy_abort_late", {31'd0, busy}, 32'd0);
    rd(32'h30, 32'd0);
    rd(32'h08, 32'd0);
    rd(32'h04, 32'd0);
    rd(32'h10, 32'd0);

    // IN[7] write while idle
    wr(32'h2C, 32'd5, 4'hF);
`ifdef BITONIC_CTRL_AUTOSTART_EN
    chk("autostart_busy", {31'd0, busy}, 32'd1);
    wait_idle(n);
    chk("autostart_cycles", n, SC + 1);
    rd(32'h4C, 32'd5);
    rd(32'h08, 32'd1);
`else
    chk("no_autostart_busy", {31'd0, busy}, 32'd0);
    repeat (SC + 2) @(posedge clk);
    #1;
    rd(32'h4C, 32'd0);
    rd(32'h08, 32'd0);
`endif
    rd(32'h2C, 32'd5);

    // Outside the window: no response expected
    rd_raw(BASE + 32'h50);
    rd_raw(BASE - 32'h4);
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
